// File: rtl/hps_pixel_loader.sv
// hps_pixel_loader: streams grayscale pixels from the HPS side into the image RAM
// using a one-cycle write request, a done_write acknowledge and a bounded wait.
module hps_pixel_loader #(
  parameter int NUM_PIXELS = 19200,
  parameter int ADDR_W     = 15,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pixel_valid,
  input  logic [7:0]        pixel_data,
  output logic              pixel_ready,
  output logic              SolicitaEscrita,
  output logic [ADDR_W-1:0] addr_in_hps,
  output logic [7:0]        dados_pixel_hps,
  input  logic              done_write,
  output logic              busy,
  output logic              load_done,
  output logic              error,
  output logic [ADDR_W-1:0] pixel_count
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  // The completion test looks at the count before it is incremented.
  localparam logic [ADDR_W-1:0] LAST_COUNT = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    REQUEST,
    WAIT_ACK,
    DONE,
    ERROR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [TO_W-1:0]   timeout_cnt;

  always_ff @(posedge clk_100) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    pixel_ready     = 1'b0;
    SolicitaEscrita = 1'b0;
    busy            = 1'b0;
    load_done       = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (start) state_next = ACCEPT;
      end
      ACCEPT: begin
        pixel_ready = 1'b1;
        busy        = 1'b1;
        if (pixel_valid) state_next = REQUEST;
      end
      REQUEST: begin
        SolicitaEscrita = 1'b1;
        busy            = 1'b1;
        state_next      = WAIT_ACK;
      end
      WAIT_ACK: begin
        busy = 1'b1;
        if (done_write) begin
          state_next = (pixel_count == LAST_COUNT) ? DONE : ACCEPT;
        end else if (timeout_cnt == TO_LAST) begin
          state_next = ERROR;
        end
      end
      DONE: begin
        busy       = 1'b1;
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and data are latched at acceptance so they hold steady until the ack.
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      base_reg        <= '0;
      addr_in_hps     <= '0;
      dados_pixel_hps <= '0;
      pixel_count     <= '0;
      timeout_cnt     <= '0;
      error           <= 1'b0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            base_reg    <= base_addr;
            pixel_count <= '0;
            error       <= 1'b0;
          end
        end
        ACCEPT: begin
          if (pixel_valid) begin
            dados_pixel_hps <= pixel_data;
            addr_in_hps     <= base_reg + pixel_count;
          end
        end
        REQUEST: begin
          timeout_cnt <= '0;
        end
        WAIT_ACK: begin
          if (done_write) begin
            pixel_count <= pixel_count + ADDR_W'(1);
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
            if (timeout_cnt == TO_LAST) error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
